// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// jk_pkg : shared mode encoding and JK next-state helper for jk_counter_reg
// Revision: 1.0
// ============================================================================
package jk_pkg;

    typedef enum logic [1:0] {
        JK_MODE_JK    = 2'd0,
        JK_MODE_LOAD  = 2'd1,
        JK_MODE_COUNT = 2'd2,
        JK_MODE_HOLD  = 2'd3
    } jk_mode_t;

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// jk_cell : single-bit combinational JK next-state
// Revision: 1.0
// ============================================================================
module jk_cell
    import jk_pkg::*;
(
    input  logic j,
    input  logic k,
    input  logic q,
    output logic q_next
);

    assign q_next = jk_next(j, k, q);

endmodule
`default_nettype wire

// File: rtl/jk_counter_reg.sv
`default_nettype none
// ============================================================================
// jk_counter_reg : N-bit JK register with load, modulo up/down count and hold
// Revision: 1.0
// ============================================================================
module jk_counter_reg
    import jk_pkg::*;
#(
    parameter int                   WIDTH     = 4,
    parameter longint unsigned      MODULUS   = 64'd1 << WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic             up,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    jk_mode_t         mode_e;
    logic [WIDTH-1:0] jk_q;
    logic [WIDTH-1:0] count_q;

    assign mode_e = jk_mode_t'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .j      (j[i]),
            .k      (k[i]),
            .q      (q[i]),
            .q_next (jk_q[i])
        );
    end

    // Out-of-range values left by JK/LOAD re-enter the range at the wrap point.
    always_comb begin
        count_q = q;
        if (up) begin
            if (q >= MAX_VAL) count_q = '0;
            else              count_q = q + WIDTH'(1);
        end else begin
            if (q == '0 || q > MAX_VAL) count_q = MAX_VAL;
            else                        count_q = q - WIDTH'(1);
        end
    end

    assign tc = en & cin & (mode_e == JK_MODE_COUNT) & (up ? (q == MAX_VAL) : (q == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            assert (!$isunknown(mode));
            case (mode_e)
                JK_MODE_JK:    q <= jk_q;
                JK_MODE_LOAD:  q <= d;
                JK_MODE_COUNT: if (cin) q <= count_q;
                default:       q <= q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_counter_reg.sv
`default_nettype none
// ============================================================================
// tb_jk_counter_reg : self-checking bench for jk_counter_reg
// Revision: 1.0
// ============================================================================
module tb_jk_counter_reg;

    localparam logic [1:0] M_JK = 2'd0, M_LD = 2'd1, M_CNT = 2'd2, M_HOLD = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0, clr = 1'b0, en = 1'b0, cin = 1'b0, up = 1'b1;
    logic [1:0] mode = M_HOLD;
    logic [3:0] j = '0, k = '0, d = '0;
    logic [3:0] q;
    logic       tc;

    logic       rreset = 1'b0, ren = 1'b0, rcin = 1'b0;
    logic [1:0] rmode = M_HOLD;
    logic [3:0] rq;
    logic       rtc;

    logic       creset = 1'b0;
    logic [1:0] cmode = M_HOLD;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    typedef struct { logic [3:0] v; int id; } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4'd0)) u_dut (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .cin(cin), .mode(mode),
        .up(up), .j(j), .k(k), .d(d), .q(q), .tc(tc)
    );

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4'd5)) u_rdut (
        .clk(clk), .reset(rreset), .clr(1'b0), .en(ren), .cin(rcin), .mode(rmode),
        .up(1'b1), .j(4'd0), .k(4'd0), .d(4'd0), .q(rq), .tc(rtc)
    );

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4'd0)) u_lo (
        .clk(clk), .reset(creset), .clr(1'b0), .en(1'b1), .cin(1'b1), .mode(cmode),
        .up(1'b1), .j(4'd0), .k(4'd0), .d(4'd0), .q(lo_q), .tc(lo_tc)
    );

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4'd0)) u_hi (
        .clk(clk), .reset(creset), .clr(1'b0), .en(1'b1), .cin(lo_tc), .mode(cmode),
        .up(1'b1), .j(4'd0), .k(4'd0), .d(4'd0), .q(hi_q), .tc(hi_tc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: each pushed expectation belongs to the next edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val($sformatf("q_step%0d", e.id), {28'd0, q}, {28'd0, e.v});
        end
    end

    task automatic step(input logic [1:0] m, input logic u, input logic c, input logic e,
                        input logic cl, input logic [3:0] jj, input logic [3:0] kk,
                        input logic [3:0] dd, input logic [3:0] eq, input logic etc);
        @(negedge clk);
        mode = m; up = u; cin = c; en = e; clr = cl; j = jj; k = kk; d = dd;
        n++;
        exp_q.push_back('{v: eq, id: n});
        #1;
        check_val($sformatf("tc_step%0d", n), {31'd0, tc}, {31'd0, etc});
    endtask

    initial begin
        #2;
        reset = 1'b1; rreset = 1'b1; creset = 1'b1;
        #1;
        check_val("reset_q", {28'd0, q}, 32'd0);
        check_val("reset_q_rv5", {28'd0, rq}, 32'd5);
        @(negedge clk);
        reset = 1'b0;

        // JK cell truth
        step(M_JK, 1, 1, 1, 0, 4'hF, 4'h0, 4'h0, 4'hF, 0);
        step(M_JK, 1, 1, 1, 0, 4'h0, 4'h5, 4'h0, 4'hA, 0);
        step(M_JK, 1, 1, 1, 0, 4'h3, 4'h3, 4'h0, 4'h9, 0);
        repeat (3) step(M_JK, 1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h9, 0);

        // Count up wrap
        step(M_LD,  1, 1, 1, 0, 0, 0, 4'd7, 4'd7, 0);
        step(M_CNT, 1, 1, 1, 0, 0, 0, 0, 4'd8, 0);
        step(M_CNT, 1, 1, 1, 0, 0, 0, 0, 4'd9, 0);
        step(M_CNT, 1, 1, 1, 0, 0, 0, 0, 4'd0, 1);
        step(M_CNT, 1, 1, 1, 0, 0, 0, 0, 4'd1, 0);

        // Count down wrap and out-of-range clamp
        step(M_LD,  0, 1, 1, 0, 0, 0, 4'd0,  4'd0,  0);
        step(M_CNT, 0, 1, 1, 0, 0, 0, 0,     4'd9,  1);
        step(M_CNT, 0, 1, 1, 0, 0, 0, 0,     4'd8,  0);
        step(M_LD,  0, 1, 1, 0, 0, 0, 4'd13, 4'd13, 0);
        step(M_CNT, 0, 1, 1, 0, 0, 0, 0,     4'd9,  0);
        step(M_LD,  1, 1, 1, 0, 0, 0, 4'd13, 4'd13, 0);
        step(M_CNT, 1, 1, 1, 0, 0, 0, 0,     4'd0,  0);

        // Gating and clear priority
        step(M_LD,   1, 1, 1, 0, 0, 0, 4'd3, 4'd3, 0);
        step(M_CNT,  1, 1, 0, 0, 0, 0, 0,    4'd3, 0);
        step(M_CNT,  1, 1, 0, 0, 0, 0, 0,    4'd3, 0);
        step(M_CNT,  1, 0, 1, 0, 0, 0, 0,    4'd3, 0);
        step(M_HOLD, 1, 1, 1, 0, 0, 0, 0,    4'd3, 0);
        step(M_CNT,  1, 1, 0, 1, 0, 0, 0,    4'd0, 0);
        step(M_LD,   1, 1, 1, 0, 0, 0, 4'd5, 4'd5, 0);
        step(M_LD,   1, 1, 1, 1, 0, 0, 4'd7, 4'd0, 0);
        step(M_HOLD, 1, 1, 1, 0, 0, 0, 0,    4'd0, 0);
        @(negedge clk);
        @(negedge clk);
        check_val("sb_drain", exp_q.size(), 32'd0);

        // Async reset mid-cycle on the RESET_VAL=5 build
        rreset = 1'b0; ren = 1'b1; rcin = 1'b1; rmode = M_CNT;
        repeat (3) @(posedge clk);
        #1;
        check_val("rv5_count8", {28'd0, rq}, 32'd8);
        #2;
        rreset = 1'b1;
        #1;
        check_val("rv5_async", {28'd0, rq}, 32'd5);
        @(posedge clk); #1;
        check_val("rv5_hold1", {28'd0, rq}, 32'd5);
        @(posedge clk); #1;
        check_val("rv5_hold2", {28'd0, rq}, 32'd5);
        @(negedge clk);
        rreset = 1'b0;
        @(posedge clk); #1;
        check_val("rv5_after", {28'd0, rq}, 32'd6);

        // Two-stage decimal cascade
        @(negedge clk);
        creset = 1'b0; cmode = M_CNT;
        repeat (99) @(posedge clk);
        #1;
        check_val("casc99_lo", {28'd0, lo_q}, 32'd9);
        check_val("casc99_hi", {28'd0, hi_q}, 32'd9);
        check_val("casc99_lo_tc", {31'd0, lo_tc}, 32'd1);
        check_val("casc99_hi_tc", {31'd0, hi_tc}, 32'd1);
        @(posedge clk); #1;
        check_val("casc100_lo", {28'd0, lo_q}, 32'd0);
        check_val("casc100_hi", {28'd0, hi_q}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
